// File: rtl/my_slave_bank.sv
// Avalon-MM slave holding CHANNELS shadow registers that are committed atomically to dout. A commit lands DELAY+1 edges after the start write.
// Writes are stalled with waitrequest while a commit is pending, and reads never stall (readdata follows one cycle after the read).
module my_slave_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DELAY_W  = 16,
    localparam int AW      = $clog2(CHANNELS + 3)
) (
    input  logic                        csi_clk,
    input  logic                        rsi_reset_n,
    input  logic [AW-1:0]               avs_s0_address,
    input  logic                        avs_s0_write,
    input  logic [31:0]                 avs_s0_writedata,
    input  logic                        avs_s0_read,
    output logic [31:0]                 avs_s0_readdata,
    output logic                        avs_s0_readdatavalid,
    output logic                        avs_s0_waitrequest,
    output logic [CHANNELS*WIDTH-1:0]   coe_s0_dout,
    output logic                        coe_s0_commit
);

    typedef enum logic [1:0] {IDLE, COUNT, APPLY} state_t;

    localparam logic [AW-1:0] A_CTRL  = AW'(CHANNELS);
    localparam logic [AW-1:0] A_DELAY = AW'(CHANNELS + 1);
    localparam logic [AW-1:0] A_STAT  = AW'(CHANNELS + 2);

    logic [CHANNELS*WIDTH-1:0] shadow;
    logic                      auto_en;
    logic [DELAY_W-1:0]        delay;
    logic [DELAY_W-1:0]        cnt;
    logic [15:0]               count;
    state_t                    state;

    logic        busy;
    logic        wr_ok;
    logic        is_shadow;
    logic        start;
    logic        clr;
    logic [31:0] rd_val;
    logic        unused_wdata;

    assign busy               = (state != IDLE);
    assign avs_s0_waitrequest = busy & avs_s0_write;
    assign wr_ok              = avs_s0_write & ~busy;
    assign is_shadow          = (avs_s0_address < A_CTRL);
    assign clr   = wr_ok && (avs_s0_address == A_CTRL) && avs_s0_writedata[2];
    assign start = wr_ok && (((avs_s0_address == A_CTRL) && avs_s0_writedata[1]) ||
                             (auto_en && is_shadow));
    assign unused_wdata = ^avs_s0_writedata;

    always_comb begin
        rd_val = '0;
        if (is_shadow) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (avs_s0_address == AW'(i)) begin
                    rd_val[WIDTH-1:0] = shadow[i*WIDTH +: WIDTH];
                end
            end
        end else if (avs_s0_address == A_CTRL) begin
            rd_val[0] = auto_en;
        end else if (avs_s0_address == A_DELAY) begin
            rd_val[DELAY_W-1:0] = delay;
        end else if (avs_s0_address == A_STAT) begin
            rd_val[31:16] = count;
            rd_val[0]     = busy;
        end
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            shadow               <= '0;
            coe_s0_dout          <= '0;
            coe_s0_commit        <= 1'b0;
            auto_en              <= 1'b0;
            delay                <= '0;
            cnt                  <= '0;
            count                <= '0;
            avs_s0_readdata      <= '0;
            avs_s0_readdatavalid <= 1'b0;
            state                <= IDLE;
        end else begin
            avs_s0_readdatavalid <= avs_s0_read;
            if (avs_s0_read) begin
                avs_s0_readdata <= rd_val;
            end
            coe_s0_commit <= 1'b0;

            if (wr_ok) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (avs_s0_address == AW'(i)) begin
                        shadow[i*WIDTH +: WIDTH] <= avs_s0_writedata[WIDTH-1:0];
                    end
                end
                if (avs_s0_address == A_CTRL) begin
                    auto_en <= avs_s0_writedata[0];
                end
                if (avs_s0_address == A_DELAY) begin
                    delay <= avs_s0_writedata[DELAY_W-1:0];
                end
            end

            // CLR only arrives while IDLE, so a GO in the same write applies the cleared shadows
            if (clr) begin
                shadow      <= '0;
                coe_s0_dout <= '0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (delay == '0) begin
                            state <= APPLY;
                        end else begin
                            cnt   <= delay;
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    cnt <= cnt - DELAY_W'(1);
                    if (cnt == DELAY_W'(1)) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    coe_s0_dout   <= shadow;
                    coe_s0_commit <= 1'b1;
                    count         <= count + 16'd1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
